dds_cmd_ctrl: RTL and testbench

//   Command sequencer between the UART byte receiver and the two DDS channels.
//   - Parses framed tuning commands from the byte stream: sync, cmd, lo, hi, [chk].
//   - Validates each frame.
//   - Hands the tuning word to the DDS core over a req/ack handshake.
//   - Mirrors the committed words on freq0/freq1.

---
 rtl/dds_cmd_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dds_cmd_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_cmd_ctrl
// Brief    : Parses framed UART tuning commands and hands tuning words to the
//            DDS core over req/ack. Define DDS_CMD_CHK_EN for the checksum byte.
// Revision : 1.0
// ============================================================================
module dds_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 20840,
  parameter int         TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        upd_req,
  output logic        upd_ch,
  output logic [15:0] upd_word,
  input  logic        upd_ack,
  output logic [15:0] freq0,
  output logic [15:0] freq1,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_CHK  = 3'd4,
    S_REQ  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              ch_q, ch_d;
  logic [15:0]       word_q, word_d;
  logic [15:0]       freq0_q, freq0_d;
  logic [15:0]       freq1_q, freq1_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              in_frame;
  logic              timeout;
  logic              err_inc;
  logic [TO_W-1:0]   to_inc;

  assign in_frame = (state_q == S_CMD) || (state_q == S_LO) ||
                    (state_q == S_HI)  || (state_q == S_CHK);
  assign to_inc   = to_cnt_q + 1'b1;
  assign timeout  = (to_inc == TO_LIMIT);

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    ch_d        = ch_q;
    word_d      = word_q;
    freq0_d     = freq0_q;
    freq1_d     = freq1_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_inc     = 1'b0;

    // A byte arriving on the timeout cycle is consumed rather than rejected.
    if (in_frame) begin
      if (rx_valid) begin
        to_cnt_d = '0;
      end else if (timeout) begin
        to_cnt_d    = '0;
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
        err_inc     = 1'b1;
      end else begin
        to_cnt_d = to_inc;
      end
    end else begin
      to_cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          if (rx_byte[7:1] != 7'd0) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_inc     = 1'b1;
          end else begin
            ch_d    = rx_byte[0];
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (rx_valid) begin
          word_d[7:0] = rx_byte;
          state_d     = S_HI;
        end
      end
      S_HI: begin
        if (rx_valid) begin
          word_d[15:8] = rx_byte;
`ifdef DDS_CMD_CHK_EN
          state_d      = S_CHK;
`else
          state_d      = S_REQ;
`endif
        end
      end
`ifdef DDS_CMD_CHK_EN
      S_CHK: begin
        if (rx_valid) begin
          if (rx_byte == ({7'd0, ch_q} ^ word_q[7:0] ^ word_q[15:8])) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_inc     = 1'b1;
          end
        end
      end
`endif
      S_REQ: begin
        // Bytes arriving while the core is busy are lost and only counted.
        if (rx_valid) begin
          err_inc = 1'b1;
        end
        if (upd_ack) begin
          if (ch_q) begin
            freq1_d = word_q;
          end else begin
            freq0_d = word_q;
          end
          frame_ok_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      ch_q        <= 1'b0;
      word_q      <= '0;
      freq0_q     <= '0;
      freq1_q     <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      ch_q        <= ch_d;
      word_q      <= word_d;
      freq0_q     <= freq0_d;
      freq1_q     <= freq1_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign upd_req   = (state_q == S_REQ);
  assign upd_ch    = ch_q;
  assign upd_word  = word_q;
  assign freq0     = freq0_q;
  assign freq1     = freq1_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_cmd_ctrl.sv
`default_nettype none
// Testbench for dds_cmd_ctrl: directed and random frames checked against a
// frame-level model of committed words and error count.
module tb_dds_cmd_ctrl;

  localparam int TO = 20840;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [7:0]  rx_byte  = 8'h00;
  logic        rx_valid = 1'b0;
  logic        upd_ack  = 1'b0;
  logic        upd_req;
  logic        upd_ch;
  logic [15:0] upd_word;
  logic [15:0] freq0;
  logic [15:0] freq1;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_cnt;

  int n_checks   = 0;
  int n_fail     = 0;
  int ok_pulses  = 0;
  int err_pulses = 0;

  logic [15:0] m_freq0 = 16'h0;
  logic [15:0] m_freq1 = 16'h0;
  int          m_err   = 0;

  dds_cmd_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .upd_req   (upd_req),
    .upd_ch    (upd_ch),
    .upd_word  (upd_word),
    .upd_ack   (upd_ack),
    .freq0     (freq0),
    .freq1     (freq1),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_ok === 1'b1) ok_pulses++;
    if (frame_err === 1'b1) err_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  function automatic void m_err_inc();
    if (m_err < 255) m_err++;
  endfunction

  // Sends a well-formed frame, then holds ack low for ack_dly cycles while
  // injecting n_ovr overrun bytes, then acks and checks the commit.
  task automatic run_good_frame(input logic ch, input logic [15:0] w,
                                input int ack_dly, input int n_ovr, input string tag);
    logic [7:0] cmd;
    int         okb;
    cmd = {7'd0, ch};
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
`ifdef DDS_CMD_CHK_EN
    send_byte(cmd ^ w[7:0] ^ w[15:8]);
`endif
    n_checks++;
    if (upd_req !== 1'b1 || upd_ch !== ch || upd_word !== w) begin
      n_fail++;
      $display("FAIL %s req: req=%b ch=%b word=%h, expected 1 %b %h", tag, upd_req, upd_ch, upd_word, ch, w);
    end
    for (int i = 0; i < ack_dly; i++) begin
      if (i < n_ovr) begin
        send_byte(8'($urandom));
        m_err_inc();
      end else begin
        tick();
      end
      n_checks++;
      if (upd_req !== 1'b1 || upd_ch !== ch || upd_word !== w || frame_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold: req=%b ch=%b word=%h err=%b, expected 1 %b %h 0", tag, upd_req, upd_ch, upd_word, frame_err, ch, w);
      end
    end
    n_checks++;
    if (err_cnt !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL %s err_cnt: got %0d expected %0d", tag, err_cnt, m_err);
    end
    okb     = ok_pulses;
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    if (ch) m_freq1 = w; else m_freq0 = w;
    n_checks++;
    if (upd_req !== 1'b0 || freq0 !== m_freq0 || freq1 !== m_freq1 || frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s commit: req=%b f0=%h f1=%h ok=%b, expected 0 %h %h 1", tag, upd_req, freq0, freq1, frame_ok, m_freq0, m_freq1);
    end
    tick();
    n_checks++;
    if (frame_ok !== 1'b0 || ok_pulses - okb != 1) begin
      n_fail++;
      $display("FAIL %s ok_pulse: ok=%b pulses=%0d, expected 0 and 1 pulse", tag, frame_ok, ok_pulses - okb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({upd_req, upd_ch, upd_word, freq0, freq1, frame_ok, frame_err, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset: req=%b ch=%b word=%h f0=%h f1=%h ok=%b err=%b cnt=%h, expected all 0",
               upd_req, upd_ch, upd_word, freq0, freq1, frame_ok, frame_err, err_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_good_frame(1'b0, 16'h1234, 3, 0, "ch0_1234");
    run_good_frame(1'b1, 16'hABCD, 1, 0, "ch1_abcd");
    run_good_frame(1'b1, 16'hA5A5, 0, 0, "sync_as_data");
  endtask

  task automatic test_bad_cmd();
    logic [7:0] cmd;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      cmd = (i == 0) ? 8'h02 : (i == 1) ? 8'h80 : 8'hFF;
      send_byte(8'hA5);
      send_byte(cmd);
      m_err_inc();
      n_checks++;
      if (frame_err !== 1'b1 || upd_req !== 1'b0 || err_cnt !== 8'(m_err)) begin
        n_fail++;
        $display("FAIL bad_cmd %h: err=%b req=%b cnt=%0d, expected 1 0 %0d", cmd, frame_err, upd_req, err_cnt, m_err);
      end
      tick();
      n_checks++;
      if (frame_err !== 1'b0 || upd_req !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_cmd_pulse %h: err=%b req=%b, expected 0 0", cmd, frame_err, upd_req);
      end
    end
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b);
      n_checks++;
      if (frame_err !== 1'b0 || upd_req !== 1'b0 || err_cnt !== 8'(m_err)) begin
        n_fail++;
        $display("FAIL idle_noise %h: err=%b req=%b cnt=%0d, expected 0 0 %0d", b, frame_err, upd_req, err_cnt, m_err);
      end
    end
  endtask

`ifdef DDS_CMD_CHK_EN
  task automatic test_chk();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h00);
    m_err_inc();
    n_checks++;
    if (frame_err !== 1'b1 || upd_req !== 1'b0 || err_cnt !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL bad_chk: err=%b req=%b cnt=%0d, expected 1 0 %0d", frame_err, upd_req, err_cnt, m_err);
    end
    tick();
  endtask
`endif

  task automatic test_overrun();
    run_good_frame(1'b0, 16'h0F0F, 5, 3, "overrun3");
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic [15:0] w;
    int          dly;
    for (int it = 0; it < 40; it++) begin
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        send_byte(b);
      end
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom) | 8'h02;
        send_byte(8'hA5);
        send_byte(b);
        m_err_inc();
        n_checks++;
        if (frame_err !== 1'b1 || err_cnt !== 8'(m_err)) begin
          n_fail++;
          $display("FAIL rand_bad %0d: err=%b cnt=%0d, expected 1 %0d", it, frame_err, err_cnt, m_err);
        end
        tick();
      end else begin
        w   = 16'($urandom);
        dly = $urandom_range(0, 4);
        run_good_frame(1'($urandom), w, dly, $urandom_range(0, dly), "rand_frame");
      end
    end
  endtask

  task automatic test_timeout();
    int  k;
    bit  seen;
    send_byte(8'hA5);
    send_byte(8'h00);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < TO + 10) begin
      tick();
      k++;
      if (frame_err === 1'b1) seen = 1'b1;
    end
    m_err_inc();
    n_checks++;
    if (!seen || k != TO || err_cnt !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL timeout: seen=%0d after %0d cycles cnt=%0d, expected err after %0d cycles cnt=%0d", seen, k, err_cnt, TO, m_err);
    end
    run_good_frame(1'b0, 16'h5A5A, 2, 0, "after_timeout");
  endtask

  task automatic test_timeout_boundary();
    int eb;
    eb = err_pulses;
    send_byte(8'hA5);
    repeat (TO - 1) tick();
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h56);
`ifdef DDS_CMD_CHK_EN
    send_byte(8'h01 ^ 8'h78 ^ 8'h56);
`endif
    n_checks++;
    if (upd_req !== 1'b1 || upd_word !== 16'h5678 || upd_ch !== 1'b1 || err_pulses != eb) begin
      n_fail++;
      $display("FAIL timeout_edge: req=%b ch=%b word=%h errs=%0d, expected 1 1 5678 0", upd_req, upd_ch, upd_word, err_pulses - eb);
    end
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    m_freq1 = 16'h5678;
    n_checks++;
    if (freq1 !== m_freq1 || freq0 !== m_freq0 || frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_edge_commit: f0=%h f1=%h ok=%b, expected %h %h 1", freq0, freq1, frame_ok, m_freq0, m_freq1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int okb;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'hEF);
    send_byte(8'hBE);
`ifdef DDS_CMD_CHK_EN
    send_byte(8'h00 ^ 8'hEF ^ 8'hBE);
`endif
    n_checks++;
    if (upd_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_req: req=%b expected 1", upd_req);
    end
    okb     = ok_pulses;
    rst_n   = 1'b0;
    upd_ack = 1'b1;
    tick();
    rst_n   = 1'b1;
    upd_ack = 1'b0;
    m_freq0 = 16'h0;
    m_freq1 = 16'h0;
    m_err   = 0;
    n_checks++;
    if ({upd_req, upd_ch, upd_word, freq0, freq1, frame_ok, frame_err, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: req=%b ch=%b word=%h f0=%h f1=%h ok=%b err=%b cnt=%h, expected all 0",
               upd_req, upd_ch, upd_word, freq0, freq1, frame_ok, frame_err, err_cnt);
    end
    repeat (2) tick();
    n_checks++;
    if (frame_ok !== 1'b0 || ok_pulses != okb || freq0 !== m_freq0 || upd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_after: ok=%b pulses=%0d f0=%h req=%b, expected 0 0 0000 0", frame_ok, ok_pulses - okb, freq0, upd_req);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5);
      send_byte(8'($urandom) | 8'h02);
      m_err_inc();
      if (i == 254 || i == 299) begin
        n_checks++;
        if (err_cnt !== 8'(m_err)) begin
          n_fail++;
          $display("FAIL saturate %0d: cnt=%0d expected %0d", i, err_cnt, m_err);
        end
      end
    end
    tick();
    n_checks++;
    if (err_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL saturate_final: cnt=%h expected ff", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_cmd();
`ifdef DDS_CMD_CHK_EN
    test_chk();
`endif
    test_overrun();
    test_random();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
